// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART serializer; define UART_TX_PARITY_EN for 8E1 framing.
// fsm_state exposes the serializer state encoding for observation.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic        CLK_100MHz,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic [15:0] IN,
    output logic        TX,
    output logic        TX_BUSY,
    output logic        TX_EMPTY,
    output logic        OVERFLOW,
    output logic [2:0]  fsm_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_en;
    logic                  pop;

    state_t      state, state_n;
    logic [15:0] baud, baud_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic        tx_n;
    logic        baud_done;
    logic [7:0]  unused_in_hi;

    assign unused_in_hi = IN[15:8];

    // Write handshake: LOAD is a one-cycle request; it is accepted on that edge
    // only if TX_BUSY (full, from registered count) is low, otherwise dropped and OVERFLOW latches.
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign wr_en      = LOAD && !fifo_full;

    assign TX_BUSY   = fifo_full;
    assign TX_EMPTY  = fifo_empty && (state == IDLE);
    assign OVERFLOW  = overflow;
    assign fsm_state = state;

    always_ff @(posedge CLK_100MHz) begin
        if (!RESET && wr_en) begin
            mem[wr_ptr] <= IN[7:0];
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (LOAD && fifo_full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign baud_done = (baud == BAUD_LAST);

    // The shift register rotates, so after 8 data bits it holds the original
    // byte again and parity can be taken straight from it.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    baud_n = baud + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n  = '0;
                    shift_n = {shift[0], shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = STOP;
                end else begin
                    baud_n = baud + 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud + 16'd1;
                end
            end
            default: begin
                baud_n    = '0;
                bit_idx_n = '0;
                state_n   = IDLE;
            end
        endcase

        // Line level is derived from the next state so TX changes on the same edge as state.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = ^shift_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            TX      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            TX      <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a queue-based model predicts FIFO contents,
// overflow and the exact TX waveform, checked every cycle.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic        tx;
    logic        busy;
    logic        empty;
    logic        ovf;
    logic [2:0]  fsm_state;

    logic [7:0] exp_q[$];
    logic       wave_q[$];
    logic       model_ovf;
    int         n_checks;
    int         n_errors;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut (
        .CLK_100MHz(clk),
        .RESET(rst),
        .LOAD(load),
        .IN(din),
        .TX(tx),
        .TX_BUSY(busy),
        .TX_EMPTY(empty),
        .OVERFLOW(ovf),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference: a byte is popped whenever the line has
    // finished its previous frame, and its whole frame is queued as line levels.
    function automatic void model_edge(input logic ld, input logic [7:0] d, input logic r);
        logic       idle;
        int         qsz;
        logic [7:0] b;
        if (r) begin
            exp_q.delete();
            wave_q.delete();
            model_ovf = 1'b0;
            return;
        end
        idle = (wave_q.size() == 0);
        if (!idle) void'(wave_q.pop_front());
        qsz = exp_q.size();
        if (idle && qsz > 0) begin
            b = exp_q.pop_front();
            repeat (CPB) wave_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CPB) wave_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
            repeat (CPB) wave_q.push_back(^b);
`endif
            repeat (CPB) wave_q.push_back(1'b1);
        end
        if (ld) begin
            if (qsz < DEPTH) exp_q.push_back(d);
            else model_ovf = 1'b1;
        end
    endfunction

    task automatic cycle(input logic ld, input logic [15:0] d, input logic r);
        load = ld;
        din  = d;
        rst  = r;
        @(posedge clk);
        model_edge(ld, d[7:0], r);
        #1;
        check("tx", tx, (wave_q.size() > 0) ? wave_q[0] : 1'b1);
        check("tx_busy", busy, exp_q.size() == DEPTH);
        check("tx_empty", empty, (exp_q.size() == 0) && (wave_q.size() == 0));
        check("overflow", ovf, model_ovf);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 16'h0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 1500 && (exp_q.size() > 0 || wave_q.size() > 0); i++) idle_cycle();
        check("drain_timeout", exp_q.size() + wave_q.size(), 0);
    endtask

    // Run until the serializer sits in its one idle cycle, so the next edge pops.
    task automatic wait_pop_edge();
        for (int i = 0; i < 200 && wave_q.size() != 0; i++) idle_cycle();
        check("wait_idle_timeout", wave_q.size(), 0);
    endtask

    initial begin
        int n;
        int sent;
        n_checks  = 0;
        n_errors  = 0;
        model_ovf = 1'b0;
        load      = 1'b0;
        din       = '0;
        rst       = 1'b1;

        // Reset state, with LOAD asserted throughout to show it is ignored.
        repeat (3) cycle(1'b1, 16'h1234, 1'b1);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_empty", empty, 1);
        check("rst_ovf", ovf, 0);
        check("rst_state", fsm_state, 0);
        repeat (3) idle_cycle();
        check("rst_no_frame", empty, 1);

        // Single byte 0x55 while idle: latency and frame length.
        cycle(1'b1, 16'hA555, 1'b0);
        n = 1;
        while (tx !== 1'b0 && n < 10) begin
            idle_cycle();
            n++;
        end
        check("first_low_latency", n, 2);
        n = 0;
        while (empty !== 1'b1 && n < 100) begin
            idle_cycle();
            n++;
        end
        check("frame_len", n, FRAME_LEN);
        drain();

        // Parity-relevant bytes and a back-to-back pair.
        cycle(1'b1, 16'h0007, 1'b0);
        cycle(1'b1, 16'hFF03, 1'b0);
        drain();

        // Burst: one byte in flight, then 16 more fill the FIFO, 17th rejected.
        do_reset();
        cycle(1'b1, 16'h00AA, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 1'b0);
        check("burst_full", busy, 1);
        cycle(1'b1, 16'h0010, 1'b0);
        check("burst_ovf", ovf, 1);
        check("burst_still_full", busy, 1);
        drain();
        check("burst_ovf_sticky", ovf, 1);

        // Coincident write and pop at count 15 (accepted) and at full (rejected).
        do_reset();
        cycle(1'b1, 16'h00A0, 1'b0);
        idle_cycle();
        for (int i = 0; i < 15; i++) cycle(1'b1, 16'(8'hB0 + i), 1'b0);
        check("cnt15_not_full", busy, 0);
        wait_pop_edge();
        cycle(1'b1, 16'h00C1, 1'b0);
        check("cnt15_accept_busy", busy, 0);
        check("cnt15_accept_ovf", ovf, 0);
        cycle(1'b1, 16'h00C2, 1'b0);
        check("now_full", busy, 1);
        wait_pop_edge();
        cycle(1'b1, 16'h00C3, 1'b0);
        check("full_pop_reject_ovf", ovf, 1);
        check("full_pop_busy", busy, 0);
        drain();

        // Reset in the middle of data bit 3 with five bytes still queued.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 16'(8'h30 + i), 1'b0);
        for (int i = 0; i < 200 && wave_q.size() != FRAME_LEN - CPB * 4 - 1; i++) idle_cycle();
        check("bit3_reached", wave_q.size(), FRAME_LEN - CPB * 4 - 1);
        check("queued_before_reset", exp_q.size(), 5);
        do_reset();
        check("mid_rst_tx", tx, 1);
        check("mid_rst_empty", empty, 1);
        repeat (60) idle_cycle();
        check("mid_rst_no_frames", empty, 1);

        // Stream 40 bytes with at most 8 queued: pointers wrap several times.
        sent = 0;
        for (int i = 0; i < 4000 && sent < 40; i++) begin
            if (exp_q.size() < 8 && $urandom_range(0, 3) == 0) begin
                cycle(1'b1, 16'($urandom), 1'b0);
                sent++;
            end else begin
                idle_cycle();
            end
        end
        check("stream_sent", sent, 40);
        drain();
        check("stream_no_ovf", ovf, 0);

        // Unconstrained random loads with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle($urandom_range(0, 2) == 0, 16'($urandom), 1'b0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 entries (16).
REQ-003 Port CLK_100MHz  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port RESET  input  1  synchronous, active-high reset.
REQ-005 Port LOAD  input  1  single-cycle write strobe; enqueues IN[7:0].
REQ-006 Port IN  input  16  write data; only IN[7:0] is used, IN[15:8] ignored.
REQ-007 Port TX  output  1  serial line, idle high.
REQ-008 Port TX_BUSY  output  1  high when FIFO full; writes are rejected.
REQ-009 Port TX_EMPTY  output  1  high when FIFO empty and the serializer is in IDLE.
REQ-010 Port OVERFLOW  output  1  sticky flag, set by a rejected write.

Function
REQ-011 FIFO SHALL be circular with DEPTH_LOG2-bit read/write pointers that wrap modulo depth, plus a (DEPTH_LOG2+1)-bit count.
REQ-012 LOAD=1 with count<depth SHALL store IN[7:0] at the write pointer and advance it on that edge.
REQ-013 LOAD=1 with count==depth SHALL leave the FIFO unchanged and set OVERFLOW=1; only RESET clears OVERFLOW.
REQ-014 Full is evaluated on the registered count: a write in the same cycle as a pop from a full FIFO SHALL be rejected.
REQ-015 A write and a pop in the same cycle with count<depth SHALL both complete and leave count unchanged.
REQ-016 TX_BUSY SHALL equal (count==depth) combinationally from registered state.
REQ-017 The serializer FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: TX=1; if count>0, the FSM pops the head byte into a shift register, advances the read pointer, and enters START on the same edge.
REQ-019 START: TX=0 for CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit index counts 0..7, then the FSM goes to PARITY (macro defined) or STOP.
REQ-021 STOP: TX=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state or bit change.
REQ-023 Latency: with the serializer idle, the first cycle of TX=0 SHALL be 2 cycles after the LOAD edge (write edge, pop edge, then TX low).
REQ-024 Frames from a non-empty FIFO SHALL be back-to-back: IDLE lasts exactly 1 cycle between a STOP and the next START.
REQ-025 TX SHALL be registered and glitch-free.

Reset
REQ-026 RESET=1 SHALL, on the next edge, set: FSM=IDLE, TX=1, pointers=0, count=0, OVERFLOW=0, baud counter=0, bit index=0; TX_BUSY=0 and TX_EMPTY=1 follow from this state.
REQ-027 RESET mid-frame SHALL abort the frame, driving TX=1 from the next edge on, and SHALL discard all queued bytes.
REQ-028 LOAD during RESET SHALL be ignored.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: PARITY state sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame is 8E1, 11 bit-times.
REQ-030 Macro undefined: the PARITY state and its logic SHALL be absent; frame is 8N1, 10 bit-times.

Verification
REQ-031 CLKS_PER_BIT=4, LOAD IN=16'h0055 while idle -> TX low 2 cycles after LOAD, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles, TX_EMPTY=1 after 40 cycles (8N1).
REQ-032 Burst 16 LOADs (8'h00..8'h0F) then a 17th -> 17th rejected, OVERFLOW=1, TX_BUSY=1 until the first pop; all 16 bytes appear in order, back-to-back.
REQ-033 Full FIFO, LOAD coincident with the pop edge -> byte rejected, OVERFLOW=1; with count=15, the same case -> accepted, count stays 15.
REQ-034 RESET asserted during DATA bit 3 with 5 bytes queued -> TX=1 next cycle, TX_EMPTY=1, no further frames.
REQ-035 UART_TX_PARITY_EN defined, IN=8'h07 -> parity bit 1; IN=8'h03 -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.
REQ-036 Write pointer wraparound: 40 bytes streamed with at most 8 queued at any time -> all 40 received in order, OVERFLOW stays 0.
